outbound_fifo_write_arbiter: RTL and testbench
==============================================

Name: outbound_fifo_write_arbiter

Overview:
- Frame-granular round-robin arbiter sharing the write side of one outbound FIFO among NUM_PORTS switch ingress paths.
- The FIFO is 9 bits wide, 8192 deep, with full-stop. Each beat is {last, byte[7:0]}.
- Once a port is granted, it owns the FIFO until it writes its last beat, so frames never interleave. The block also enforces a maximum frame length by truncating over-length frames, and counts frames.

Parameters:
- NUM_PORTS, 4, number of requesting ports (2..8).
- DATA_WIDTH, 9, beat width; bit DATA_WIDTH-1 is end-of-frame (last).
- MAX_FRAME_BYTES, 2048, maximum beats per frame written to the FIFO (range 2..65535).
- CNT_WIDTH, 16, width of the statistics counters.

Ports:
- CLK  in  1  single clock for the block and the FIFO write side.
- RESET_N  in  1  reset, synchronous, active-low.
- REQ_VALID  in  NUM_PORTS  per-port beat valid.
- REQ_DATA  in  NUM_PORTS*DATA_WIDTH  per-port beat; port p uses slice [p*DATA_WIDTH +: DATA_WIDTH].
- REQ_READY  out  NUM_PORTS  per-port beat accept.
- FIFO_FULL  in  1  outbound FIFO FULL.
- FIFO_WE  out  1  outbound FIFO write enable, active-high.
- FIFO_DATA  out  DATA_WIDTH  outbound FIFO DATA.
- GRANT  out  NUM_PORTS  one-hot owner of the FIFO; all-zero when idle.
- BUSY  out  1  high in XFER or DRAIN.
- FRAME_COUNT  out  CNT_WIDTH  frames completed (normal + truncated), saturating.
- TRUNC_COUNT  out  CNT_WIDTH  frames truncated, saturating.

Behaviour:
- Reset values (any clock edge with RESET_N=0): state IDLE, GRANT=0, BUSY=0, counters=0, beat count=0, last_grant pointer=NUM_PORTS-1 (so port 0 wins first). REQ_READY=0 and FIFO_WE=0 while in reset.
- Reset mid-frame aborts the frame outright. The partial frame already in the FIFO is not closed; the FIFO is reset by its own reset.
- State machine: IDLE, XFER, DRAIN.
- IDLE:
  - REQ_READY=0, FIFO_WE=0.
  - If any REQ_VALID, select the first valid port searching last_grant+1, last_grant+2, ... modulo NUM_PORTS.
  - On the next edge: GRANT is registered one-hot, last_grant updates to the winner, beat count clears, state goes to XFER.
  - Arbitration latency: 1 cycle from VALID to GRANT.
- XFER, granted port g:
  - REQ_READY[g] = !FIFO_FULL; all other REQ_READY = 0.
  - FIFO_WE = REQ_VALID[g] & !FIFO_FULL, combinational. FIFO_WE is never asserted while FIFO_FULL=1.
  - FIFO_DATA = REQ_DATA[g], except as noted for truncation below.
  - Each accepted beat increments the beat count.
  - Accepted beat with last=1: FRAME_COUNT+1, GRANT cleared, state goes to IDLE on the same edge. There is at least 1 idle cycle between frames.
  - Accepted beat with beat count = MAX_FRAME_BYTES-1 and last=0: FIFO_DATA last bit is forced to 1. FRAME_COUNT+1, TRUNC_COUNT+1, state goes to DRAIN.
  - If the MAX_FRAME_BYTES-th beat carries last=1 itself, it is a normal completion, not a truncation.
  - Stalls (REQ_VALID=0 or FIFO_FULL=1) hold all state; there is no timeout.
- DRAIN, granted port g:
  - REQ_READY[g]=1 regardless of FIFO_FULL; FIFO_WE=0.
  - Beats from g are discarded.
  - Accepted beat with last=1: GRANT cleared, state goes to IDLE. No counter change.
- Requests from non-granted ports are held off (READY=0). They must keep VALID and DATA stable until accepted.
- Counters saturate at all-ones. FRAME_COUNT and TRUNC_COUNT may increment on the same edge.
- A port that deasserts VALID mid-frame keeps the grant. Ownership ends only on last.

Test Plan:
- Single port: port 0 sends 3 beats 0x0AA, 0x0BB, 0x1CC, FIFO_FULL=0 -> GRANT=0001 one cycle after VALID. FIFO_WE high 3 consecutive cycles with DATA 0x0AA, 0x0BB, 0x1CC. GRANT returns to 0. FRAME_COUNT=1.
- Round-robin: all 4 ports continuously request 2-beat frames -> grant order 0,1,2,3,0. No beat interleaving in the FIFO. FRAME_COUNT=5 after 5 frames.
- Backpressure: FIFO_FULL=1 for 4 cycles mid-frame -> REQ_READY[g]=0 and FIFO_WE=0 for those 4 cycles. The beat is held and written on the first cycle FULL=0. No data lost or duplicated.
- Truncation: MAX_FRAME_BYTES=4, port 2 sends 6 beats with last on beat 6 -> 4 FIFO writes, the 4th with bit8=1. Beats 5 and 6 accepted but not written. TRUNC_COUNT=1, FRAME_COUNT=1, then IDLE.
- Exact-length: MAX_FRAME_BYTES=4, 4-beat frame with last on beat 4 -> 4 writes, TRUNC_COUNT stays 0.
- Reset mid-frame: RESET_N=0 for 1 cycle during XFER on port 1 -> next cycle GRANT=0, FIFO_WE=0, counters 0. With ports 0 and 1 both requesting afterwards, port 0 is granted first.

Source files
------------

// File: rtl/outbound_fifo_write_arbiter.sv
// Frame-granular round-robin arbiter for the write side of a shared outbound FIFO.
// A granted port owns the FIFO until its last beat; over-length frames are truncated and drained.
module outbound_fifo_write_arbiter #(
    parameter int NUM_PORTS       = 4,
    parameter int DATA_WIDTH      = 9,
    parameter int MAX_FRAME_BYTES = 2048,
    parameter int CNT_WIDTH       = 16
) (
    input  logic                            CLK,
    input  logic                            RESET_N,
    input  logic [NUM_PORTS-1:0]            REQ_VALID,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] REQ_DATA,
    output logic [NUM_PORTS-1:0]            REQ_READY,
    input  logic                            FIFO_FULL,
    output logic                            FIFO_WE,
    output logic [DATA_WIDTH-1:0]           FIFO_DATA,
    output logic [NUM_PORTS-1:0]            GRANT,
    output logic                            BUSY,
    output logic [CNT_WIDTH-1:0]            FRAME_COUNT,
    output logic [CNT_WIDTH-1:0]            TRUNC_COUNT
);

    localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int BW = $clog2(MAX_FRAME_BYTES + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_XFER,
        ST_DRAIN
    } state_t;

    state_t                 state_q;
    logic [NUM_PORTS-1:0]   grant_q;
    logic [PW-1:0]          gidx_q;
    logic [PW-1:0]          last_q;
    logic [BW-1:0]          beat_q;
    logic                   busy_q;
    logic [CNT_WIDTH-1:0]   frame_cnt_q;
    logic [CNT_WIDTH-1:0]   frame_cnt_d;
    logic [CNT_WIDTH-1:0]   trunc_cnt_q;
    logic [CNT_WIDTH-1:0]   trunc_cnt_d;

    logic [DATA_WIDTH-1:0]  g_data;
    logic                   g_valid;
    logic                   g_last;
    logic                   at_max;
    logic                   xfer_acc;
    logic                   drain_acc;
    logic                   frame_done;
    logic                   frame_trunc;

    logic                   found;
    logic [PW-1:0]          win_idx;
    logic [PW-1:0]          cand;
    logic [NUM_PORTS-1:0]   win_oh;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // Granted-port view of the request bus
    always_comb begin
        g_data    = REQ_DATA[int'(gidx_q)*DATA_WIDTH +: DATA_WIDTH];
        g_valid   = REQ_VALID[gidx_q];
        g_last    = g_data[DATA_WIDTH-1];
        at_max    = (beat_q == BW'(MAX_FRAME_BYTES - 1));
        xfer_acc  = RESET_N && (state_q == ST_XFER) && g_valid && !FIFO_FULL;
        drain_acc = RESET_N && (state_q == ST_DRAIN) && g_valid;
    end

    always_comb begin
        REQ_READY = '0;
        if (RESET_N) begin
            if (state_q == ST_XFER && !FIFO_FULL) begin
                REQ_READY = grant_q;
            end else if (state_q == ST_DRAIN) begin
                REQ_READY = grant_q;
            end
        end
        FIFO_WE   = xfer_acc;
        FIFO_DATA = g_data;
        // The MAX-th beat closes the frame in the FIFO even if the source keeps going
        if (state_q == ST_XFER && at_max) begin
            FIFO_DATA[DATA_WIDTH-1] = 1'b1;
        end
    end

    // Round-robin search starting just after the previous winner
    always_comb begin
        found   = 1'b0;
        win_idx = last_q;
        cand    = last_q;
        for (int i = 1; i <= NUM_PORTS; i++) begin
            cand = PW'((int'(last_q) + i) % NUM_PORTS);
            if (!found && REQ_VALID[cand]) begin
                found   = 1'b1;
                win_idx = cand;
            end
        end
        win_oh          = '0;
        win_oh[win_idx] = 1'b1;
    end

    always_comb begin
        frame_done  = xfer_acc && (g_last || at_max);
        frame_trunc = xfer_acc && !g_last && at_max;
        frame_cnt_d = frame_done  ? sat_inc(frame_cnt_q) : frame_cnt_q;
        trunc_cnt_d = frame_trunc ? sat_inc(trunc_cnt_q) : trunc_cnt_q;
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state_q     <= ST_IDLE;
            grant_q     <= '0;
            gidx_q      <= '0;
            last_q      <= PW'(NUM_PORTS - 1);
            beat_q      <= '0;
            busy_q      <= 1'b0;
            frame_cnt_q <= '0;
            trunc_cnt_q <= '0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
            trunc_cnt_q <= trunc_cnt_d;
            case (state_q)
                ST_IDLE: begin
                    if (found) begin
                        grant_q <= win_oh;
                        gidx_q  <= win_idx;
                        last_q  <= win_idx;
                        beat_q  <= '0;
                        busy_q  <= 1'b1;
                        state_q <= ST_XFER;
                    end
                end
                ST_XFER: begin
                    if (xfer_acc) begin
                        beat_q <= beat_q + 1'b1;
                        if (g_last) begin
                            grant_q <= '0;
                            busy_q  <= 1'b0;
                            state_q <= ST_IDLE;
                        end else if (at_max) begin
                            state_q <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (drain_acc && g_last) begin
                        grant_q <= '0;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    grant_q <= '0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign GRANT       = grant_q;
    assign BUSY        = busy_q;
    assign FRAME_COUNT = frame_cnt_q;
    assign TRUNC_COUNT = trunc_cnt_q;

endmodule

// File: tb/tb_outbound_fifo_write_arbiter.sv
// Randomized scoreboard bench: per-port frame sources, round-robin frame-order model, FIFO write monitor.
module tb_outbound_fifo_write_arbiter;

    localparam int NP   = 4;
    localparam int DW   = 9;
    localparam int MAXB = 4;
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic             CLK = 1'b0;
    logic             RESET_N;
    logic [NP-1:0]    REQ_VALID;
    logic [NP*DW-1:0] REQ_DATA;
    logic [NP-1:0]    REQ_READY;
    logic             FIFO_FULL;
    logic             FIFO_WE;
    logic [DW-1:0]    FIFO_DATA;
    logic [NP-1:0]    GRANT;
    logic             BUSY;
    logic [CW-1:0]    FRAME_COUNT;
    logic [CW-1:0]    TRUNC_COUNT;

    always #5 CLK = ~CLK;

    outbound_fifo_write_arbiter #(
        .NUM_PORTS(NP), .DATA_WIDTH(DW), .MAX_FRAME_BYTES(MAXB), .CNT_WIDTH(CW)
    ) dut (
        .CLK(CLK), .RESET_N(RESET_N), .REQ_VALID(REQ_VALID), .REQ_DATA(REQ_DATA),
        .REQ_READY(REQ_READY), .FIFO_FULL(FIFO_FULL), .FIFO_WE(FIFO_WE),
        .FIFO_DATA(FIFO_DATA), .GRANT(GRANT), .BUSY(BUSY),
        .FRAME_COUNT(FRAME_COUNT), .TRUNC_COUNT(TRUNC_COUNT)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    logic [8:0] pq    [NP][$];
    logic [8:0] stage [NP][$];
    logic [8:0] exp_d [$];
    int         exp_p [$];
    bit         inframe [NP];
    bit         full_en = 0;
    bit         gap_en  = 0;
    int         model_last   = NP - 1;
    int         model_frames = 0;
    int         model_trunc  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Frame sources: first beat of a frame is presented at once, later beats may gap
    initial begin
        logic [NP-1:0] acc;
        logic [8:0]    b;
        REQ_VALID = '0;
        REQ_DATA  = '0;
        FIFO_FULL = 1'b0;
        forever begin
            @(negedge CLK);
            acc = REQ_VALID & REQ_READY;
            @(posedge CLK);
            #1;
            for (int p = 0; p < NP; p++) begin
                if (acc[p] && pq[p].size() > 0) begin
                    b = pq[p].pop_front();
                    inframe[p] = !b[8];
                end
                if (pq[p].size() == 0) begin
                    REQ_VALID[p] = 1'b0;
                end else if (!(REQ_VALID[p] && !acc[p])) begin
                    REQ_VALID[p] = !inframe[p] || !gap_en || ($urandom_range(3) != 0);
                    REQ_DATA[p*DW +: DW] = pq[p][0];
                end
            end
            FIFO_FULL = full_en && ($urandom_range(3) == 0);
        end
    end

    // Monitor: every FIFO write is checked against the next expected beat
    initial begin
        logic [8:0] ed;
        int         ep;
        forever begin
            @(negedge CLK);
            if (RESET_N === 1'b1 && FIFO_WE === 1'b1) begin
                check("we_while_full", 32'(FIFO_FULL), 32'd0);
                if (exp_d.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_write: got %0h expected none", FIFO_DATA);
                end else begin
                    ed = exp_d.pop_front();
                    ep = exp_p.pop_front();
                    check("fifo_data", 32'(FIFO_DATA), 32'(ed));
                    check("write_grant", 32'(GRANT), 32'(1) << ep);
                    check("write_busy", 32'(BUSY), 32'd1);
                end
            end
        end
    end

    task automatic add_beat(input int p, input logic [8:0] b);
        stage[p].push_back(b);
    endtask

    task automatic add_frame(input int p, input int len);
        logic [7:0] d;
        for (int k = 0; k < len; k++) begin
            d = 8'($urandom);
            stage[p].push_back({(k == len - 1), d});
        end
    endtask

    // Reference: whole frames leave in round-robin order among ports with pending frames
    task automatic commit_phase();
        int   idx [NP];
        int   win;
        int   len;
        logic [8:0] b;
        for (int p = 0; p < NP; p++) idx[p] = 0;
        win = 0;
        while (win >= 0) begin
            win = -1;
            for (int i = 1; i <= NP; i++) begin
                int c;
                c = (model_last + i) % NP;
                if (win < 0 && idx[c] < stage[c].size()) win = c;
            end
            if (win >= 0) begin
                len = 0;
                do begin
                    b = stage[win][idx[win] + len];
                    len++;
                end while (!b[8]);
                for (int k = 0; k < len && k < MAXB; k++) begin
                    b = stage[win][idx[win] + k];
                    if (k == MAXB - 1) b[8] = 1'b1;
                    exp_d.push_back(b);
                    exp_p.push_back(win);
                end
                if (model_frames < CMAX) model_frames++;
                if (len > MAXB && model_trunc < CMAX) model_trunc++;
                idx[win] += len;
                model_last = win;
            end
        end
        for (int p = 0; p < NP; p++) begin
            foreach (stage[p][k]) pq[p].push_back(stage[p][k]);
            stage[p].delete();
        end
    endtask

    task automatic wait_done(input string name);
        int  cyc;
        bit  pending;
        cyc = 0;
        pending = 1;
        while (pending && cyc < 4000) begin
            @(posedge CLK);
            #1;
            cyc++;
            pending = (exp_d.size() != 0) || (GRANT !== '0);
            for (int p = 0; p < NP; p++) if (pq[p].size() != 0) pending = 1;
        end
        if (pending) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s_timeout: got %0d beats outstanding expected 0", name, exp_d.size());
        end
        repeat (2) @(negedge CLK);
        check({name, "_frames"}, 32'(FRAME_COUNT), 32'(model_frames));
        check({name, "_trunc"}, 32'(TRUNC_COUNT), 32'(model_trunc));
        check({name, "_exp_left"}, 32'(exp_d.size()), 32'd0);
    endtask

    initial begin
        int cyc;
        RESET_N = 1'b0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("rst_grant", 32'(GRANT), 32'd0);
        check("rst_busy", 32'(BUSY), 32'd0);
        check("rst_frames", 32'(FRAME_COUNT), 32'd0);
        check("rst_trunc", 32'(TRUNC_COUNT), 32'd0);
        check("rst_ready", 32'(REQ_READY), 32'd0);
        check("rst_we", 32'(FIFO_WE), 32'd0);
        @(posedge CLK);
        #2 RESET_N = 1'b1;

        // Single port, one-cycle arbitration latency
        @(posedge CLK);
        #2;
        add_beat(0, 9'h0AA);
        add_beat(0, 9'h0BB);
        add_beat(0, 9'h1CC);
        commit_phase();
        @(negedge CLK);
        @(negedge CLK);
        check("latency_pre", 32'(GRANT), 32'd0);
        @(negedge CLK);
        check("latency_grant", 32'(GRANT), 32'b0001);
        wait_done("single");

        // All ports with back-to-back 2-beat frames
        @(posedge CLK);
        #2;
        for (int p = 0; p < NP; p++) begin
            add_frame(p, 2);
            add_frame(p, 2);
        end
        commit_phase();
        wait_done("rr");

        // Truncation and exact-length frames
        @(posedge CLK);
        #2;
        add_frame(2, 6);
        commit_phase();
        wait_done("trunc");
        @(posedge CLK);
        #2;
        add_frame(1, 4);
        commit_phase();
        wait_done("exact");

        // Randomized phases with backpressure and source gaps
        full_en = 1;
        gap_en  = 1;
        for (int ph = 0; ph < 14; ph++) begin
            @(posedge CLK);
            #2;
            for (int p = 0; p < NP; p++) begin
                int nf;
                nf = $urandom_range(3);
                for (int f = 0; f < nf; f++) add_frame(p, $urandom_range(7, 1));
            end
            commit_phase();
            wait_done("rand");
        end

        // Reset in the middle of a frame on port 1
        full_en = 0;
        gap_en  = 0;
        @(posedge CLK);
        #2;
        add_frame(1, 7);
        commit_phase();
        cyc = 0;
        while (GRANT !== 4'b0010 && cyc < 50) begin
            @(negedge CLK);
            cyc++;
        end
        check("midrst_granted", 32'(GRANT), 32'b0010);
        @(posedge CLK);
        #2;
        RESET_N = 1'b0;
        for (int p = 0; p < NP; p++) begin
            pq[p].delete();
            inframe[p] = 0;
        end
        REQ_VALID = '0;
        exp_d.delete();
        exp_p.delete();
        model_last   = NP - 1;
        model_frames = 0;
        model_trunc  = 0;
        @(posedge CLK);
        #2 RESET_N = 1'b1;
        @(negedge CLK);
        check("midrst_grant", 32'(GRANT), 32'd0);
        check("midrst_we", 32'(FIFO_WE), 32'd0);
        check("midrst_frames", 32'(FRAME_COUNT), 32'd0);
        check("midrst_trunc", 32'(TRUNC_COUNT), 32'd0);
        @(posedge CLK);
        #2;
        add_frame(1, 2);
        add_frame(0, 3);
        commit_phase();
        wait_done("post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
